// File: rtl/dma_multichannel.sv
// dma_multichannel: round-robin multi-channel DMA engine.
// The CPU programs SRC/DST/COUNT/CTRL per channel through the config port.
// The engine requests the bus with hold_req and, once bus_grant is high,
// moves one word per two cycles: an RD cycle that latches mem_rdata into the
// word buffer, then a WR cycle that writes the buffer out. Channels are
// re-arbitrated after every word.
//
// Optional build macro DMA_IRQ_EN: adds the irq output, CTRL bit6 IE and
// write-1-to-clear on CTRL bit4 DONE.
//
// CTRL layout: bit0 START (w1), bit1 SRC_INC, bit2 DST_INC, bit3 ABORT (w1),
// bit4 DONE (ro, w1c with irq), bit5 BUSY (ro), bit6 IE (irq build only).
//
// Bus handshake: hold_req is a level request held from REQ through the last
// WR; bus_grant is sampled only at the REQ->RD and WR->RD decisions, so a
// grant drop during RD still finishes that word's WR before the engine
// returns to REQ.
module dma_multichannel #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16,
    parameter int ADDR_STEP = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_CH)+1:0]  cfg_addr,
    input  logic [DATA_W-1:0]          cfg_wdata,
    output logic [DATA_W-1:0]          cfg_rdata,
    output logic                       hold_req,
    input  logic                       bus_grant,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
`ifdef DMA_IRQ_EN
    output logic                       irq,
`endif
    output logic [NUM_CH-1:0]          ch_busy
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] REG_SRC   = 2'd0;
    localparam logic [1:0] REG_DST   = 2'd1;
    localparam logic [1:0] REG_COUNT = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RD   = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    // sel_q is both the channel being moved and the last-serviced channel
    // for the round-robin search.
    logic [CH_W-1:0]   sel_q, sel_d;
    logic [DATA_W-1:0] buf_q, buf_d;

    logic [ADDR_W-1:0] src_q [NUM_CH];
    logic [ADDR_W-1:0] src_d [NUM_CH];
    logic [ADDR_W-1:0] dst_q [NUM_CH];
    logic [ADDR_W-1:0] dst_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] busy_q, busy_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] sinc_q, sinc_d;
    logic [NUM_CH-1:0] dinc_q, dinc_d;
`ifdef DMA_IRQ_EN
    logic [NUM_CH-1:0] ie_q, ie_d;
    logic              irq_q, irq_d;
`endif

    int                cfg_ch;
    logic [1:0]        cfg_reg;
    logic              pick_found;
    logic [CH_W-1:0]   pick_ch;

    assign cfg_ch  = int'(cfg_addr >> 2);
    assign cfg_reg = cfg_addr[1:0];
    assign ch_busy = busy_q;

    // Per-channel register updates: config writes first, then the WR-cycle
    // word update, so the engine wins any same-cycle collision.
    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = done_q;
        sinc_d = sinc_q;
        dinc_d = dinc_q;
`ifdef DMA_IRQ_EN
        ie_d   = ie_q;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_we && (cfg_ch == i)) begin
                case (cfg_reg)
                    REG_SRC: begin
                        if (!busy_q[i]) src_d[i] = ADDR_W'(cfg_wdata);
                    end
                    REG_DST: begin
                        if (!busy_q[i]) dst_d[i] = ADDR_W'(cfg_wdata);
                    end
                    REG_COUNT: begin
                        if (!busy_q[i]) cnt_d[i] = CNT_W'(cfg_wdata);
                    end
                    default: begin
                        sinc_d[i] = cfg_wdata[1];
                        dinc_d[i] = cfg_wdata[2];
`ifdef DMA_IRQ_EN
                        ie_d[i]   = cfg_wdata[6];
                        if (cfg_wdata[4]) done_d[i] = 1'b0;
`endif
                        // A zero-length START completes immediately.
                        if (cfg_wdata[0] && !busy_q[i]) begin
                            if (cnt_q[i] != '0) begin
                                busy_d[i] = 1'b1;
                                done_d[i] = 1'b0;
                            end else begin
                                done_d[i] = 1'b1;
                            end
                        end
                        if (cfg_wdata[3]) busy_d[i] = 1'b0;
                    end
                endcase
            end

            if ((state_q == ST_WR) && (int'(sel_q) == i)) begin
                if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_W'(1);
                if (sinc_q[i]) src_d[i] = src_q[i] + ADDR_W'(ADDR_STEP);
                if (dinc_q[i]) dst_d[i] = dst_q[i] + ADDR_W'(ADDR_STEP);
                if (cnt_q[i] == CNT_W'(1)) begin
                    busy_d[i] = 1'b0;
                    // An abort landing on the last word suppresses DONE.
                    if (busy_q[i] &&
                        !(cfg_we && (cfg_ch == i) && (cfg_reg == REG_CTRL) && cfg_wdata[3]))
                        done_d[i] = 1'b1;
                end
            end
        end
    end

    // Round-robin pick: first channel still busy after this cycle, searching
    // upward from the one after the last-serviced channel.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_ch    = sel_q;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(sel_q) + k) % NUM_CH;
            if (!pick_found && busy_d[idx]) begin
                pick_found = 1'b1;
                pick_ch    = CH_W'(idx);
            end
        end
    end

    // Transfer FSM next-state and bus outputs.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        buf_d     = buf_q;
        hold_req  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (|busy_q) state_d = ST_REQ;
            end
            ST_REQ: begin
                hold_req = 1'b1;
                if (!pick_found) begin
                    state_d = ST_IDLE;
                end else if (bus_grant) begin
                    state_d = ST_RD;
                    sel_d   = pick_ch;
                end
            end
            ST_RD: begin
                hold_req = 1'b1;
                mem_read = 1'b1;
                mem_addr = src_q[sel_q];
                buf_d    = mem_rdata;
                state_d  = ST_WR;
            end
            default: begin
                hold_req  = 1'b1;
                mem_write = 1'b1;
                mem_addr  = dst_q[sel_q];
                mem_wdata = buf_q;
                if (!pick_found) begin
                    state_d = ST_IDLE;
                end else if (bus_grant) begin
                    state_d = ST_RD;
                    sel_d   = pick_ch;
                end else begin
                    state_d = ST_REQ;
                end
            end
        endcase
    end

    // Combinational readback of the addressed channel register.
    always_comb begin
        cfg_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == i) begin
                case (cfg_reg)
                    REG_SRC:   cfg_rdata = DATA_W'(src_q[i]);
                    REG_DST:   cfg_rdata = DATA_W'(dst_q[i]);
                    REG_COUNT: cfg_rdata = DATA_W'(cnt_q[i]);
                    default: begin
                        cfg_rdata[1] = sinc_q[i];
                        cfg_rdata[2] = dinc_q[i];
                        cfg_rdata[4] = done_q[i];
                        cfg_rdata[5] = busy_q[i];
`ifdef DMA_IRQ_EN
                        cfg_rdata[6] = ie_q[i];
`endif
                    end
                endcase
            end
        end
    end

`ifdef DMA_IRQ_EN
    // Interrupt level: any channel with DONE and IE set, one cycle later.
    always_comb begin
        irq_d = |(done_q & ie_q);
    end

    // Interrupt register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
            ie_q  <= '0;
        end else begin
            irq_q <= irq_d;
            ie_q  <= ie_d;
        end
    end

    assign irq = irq_q;
`endif

    // FSM state, channel select and word buffer. The select resets to the
    // top channel so the first search after reset begins at channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= CH_W'(NUM_CH - 1);
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            buf_q   <= buf_d;
        end
    end

    // Channel register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                src_q[i] <= '0;
                dst_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            busy_q <= '0;
            done_q <= '0;
            sinc_q <= '0;
            dinc_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                src_q[i] <= src_d[i];
                dst_q[i] <= dst_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            busy_q <= busy_d;
            done_q <= done_d;
            sinc_q <= sinc_d;
            dinc_q <= dinc_d;
        end
    end

endmodule
